led_pattern_seq: RTL

//  Parametrised LED pattern sequencer for the board front panel; successor to the fixed 4-LED chase timer.

---
 rtl/led_pattern_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: switch-selected LED pattern sequencer with debounced pause/speed buttons
module led_pattern_seq #(
  parameter int NUM_LEDS   = 4,
  parameter int TICK_DIV   = 25_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                btn_pause,
  input  logic                btn_speed,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_pulse,
  output logic                paused,
  output logic [1:0]          speed
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES);
  typedef enum logic {UP, DOWN} dir_t;
  logic [1:0] btn_s1, btn_s2, press, mode_s1, mode_s2, mode_prev, speed_n;
  logic [CW-1:0] cnt, cnt_n, last;
  logic [NUM_LEDS-1:0] led_n, pat;
  dir_t dir, dir_n, pat_dir;
  logic paused_n, step, term, mode_chg;
  // two-flop synchronisers for the raw buttons and mode switches, plus the previous synced mode
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      mode_s1 <= '0;
      mode_s2 <= '0;
      mode_prev <= '0;
    end else begin
      btn_s1 <= {btn_speed, btn_pause};
      btn_s2 <= btn_s1;
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      mode_prev <= mode_s2;
    end
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic deb;
    logic [DW-1:0] dcnt;
    // press fires on the same edge the debounced state rises
    assign press[i] = btn_s2[i] && !deb && dcnt == DW'(DEB_CYCLES - 1);
    // accept a new level only after it has differed from the debounced state for DEB_CYCLES samples
    always_ff @(posedge sys_clk)
      if (sys_rst) begin
        deb <= 1'b0;
        dcnt <= '0;
      end else if (btn_s2[i] == deb) dcnt <= '0;
      else if (dcnt == DW'(DEB_CYCLES - 1)) begin
        deb <= btn_s2[i];
        dcnt <= '0;
      end else dcnt <= dcnt + 1'b1;
  end
  assign last = CW'((TICK_DIV >> speed) - 1);
  assign term = cnt == last;
  assign mode_chg = mode_s2 != mode_prev;
  assign pat_dir = dir == UP ? (led[NUM_LEDS-1] ? DOWN : UP) : (led[0] ? UP : DOWN);
  assign pat = mode_s2 == 2'd0 ? {led[NUM_LEDS-2:0], led[NUM_LEDS-1]} :
               mode_s2 == 2'd1 ? (pat_dir == UP ? led << 1 : led >> 1) :
               mode_s2 == 2'd2 ? ~led : led + 1'b1;
  // next state: mode change beats speed press beats a normal tick; pause toggles regardless
  always_comb begin
    led_n = led;
    cnt_n = cnt;
    dir_n = dir;
    speed_n = speed;
    step = 1'b0;
    paused_n = paused ^ press[0];
    if (mode_chg) begin
      led_n = mode_s2[1] ? '0 : NUM_LEDS'(1);
      dir_n = UP;
      cnt_n = '0;
    end else if (press[1]) begin
      speed_n = speed + 1'b1;
      cnt_n = '0;
    end else if (!paused) begin
      step = term;
      cnt_n = term ? '0 : cnt + 1'b1;
      led_n = term ? pat : led;
      dir_n = term ? pat_dir : dir;
    end
  end
  // sequencer state register; step_pulse lines up with the first cycle of the new led value
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      led <= NUM_LEDS'(1);
      cnt <= '0;
      dir <= UP;
      paused <= 1'b0;
      speed <= '0;
      step_pulse <= 1'b0;
    end else begin
      led <= led_n;
      cnt <= cnt_n;
      dir <= dir_n;
      paused <= paused_n;
      speed <= speed_n;
      step_pulse <= step;
    end
endmodule
